// File: rtl/enc_sched_pkg.sv
// Shared types and helpers for the encounter spawn scheduler.
package enc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFER    = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  localparam logic [1:0] ENC_NONE = 2'd0;
  localparam logic [1:0] ENC1     = 2'd1;
  localparam logic [1:0] ENC2     = 2'd2;
  localparam logic [1:0] ENC3     = 2'd3;

  // Next request index in round-robin order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Map a request index to the type code presented to the spawner.
  function automatic logic [1:0] idx_to_type(input logic [1:0] idx);
    case (idx)
      2'd0:    return ENC1;
      2'd1:    return ENC2;
      default: return ENC3;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: search starts one past the last grant.
module rr_arbiter3
  import enc_sched_pkg::*;
(
  input  logic [2:0] pending_i,
  input  logic [1:0] last_grant_i,
  output logic       grant_valid_o,
  output logic [1:0] grant_idx_o
);

  logic [1:0] idx;
  logic       hit;

  // Walk the three candidates in priority order and take the first pending one.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = 2'd0;
    idx           = rr_next(last_grant_i);
    hit           = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hit = (idx == 2'd0) ? pending_i[0] :
            (idx == 2'd1) ? pending_i[1] : pending_i[2];
      if (!grant_valid_o && hit) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = idx;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/enc_spawn_scheduler.sv
// Encounter spawn scheduler: latches request edges, grants round-robin,
// offers to the spawner, waits for completion, then applies a cooldown.
module enc_spawn_scheduler
  import enc_sched_pkg::*;
#(
  parameter int COOLDOWN_BASE = 50_000_000,
  parameter int TIMEOUT       = 500_000_000,
  parameter int CNT_W         = 31,
  parameter int DROP_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              game_active,
  input  logic [2:0]        enc_req,
  input  logic [1:0]        difficulty,
  input  logic              spawn_ready,
  input  logic              spawn_done,
  output logic              spawn_valid,
  output logic [1:0]        spawn_type,
  output logic              busy,
  output logic [2:0]        pending,
  output logic [DROP_W-1:0] drop_count,
  output logic              timeout_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        req_q;
  logic [2:0]        pending_q, pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              tout_q, tout_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        win_q, win_d;

  logic [2:0]        rise, clr, drops;
  logic              handshake;
  logic [1:0]        drop_inc;
  logic [DROP_W+1:0] drop_sum;
  logic [CNT_W-1:0]  cool_load;
  logic              grant_valid;
  logic [1:0]        grant_idx;

  rr_arbiter3 u_arb (
    .pending_i     (pending_q),
    .last_grant_i  (last_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Request bookkeeping: edge detect, pending set/clear and saturating drop count.
  always_comb begin
    rise      = enc_req & ~req_q & {3{game_active}};
    handshake = (state_q == OFFER) && spawn_ready && game_active;
    clr       = handshake ? (3'b001 << win_q) : 3'b000;
    drops     = rise & pending_q & ~clr;
    pending_d = game_active ? ((pending_q & ~clr) | rise) : 3'b000;
    drop_inc  = {1'b0, drops[0]} + {1'b0, drops[1]} + {1'b0, drops[2]};
    drop_sum  = (DROP_W+2)'(drop_q) + (DROP_W+2)'(drop_inc);
    drop_d    = (drop_sum > (DROP_W+2)'({DROP_W{1'b1}})) ? {DROP_W{1'b1}}
                                                         : drop_sum[DROP_W-1:0];
    cool_load = CNT_W'(COOLDOWN_BASE >> difficulty);
  end

  // Next-state logic for the spawn FSM plus its decoded outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    tout_d      = tout_q;
    if (!game_active) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (grant_valid) begin
            state_d = OFFER;
            win_d   = grant_idx;
          end
        end
        OFFER: begin
          if (spawn_ready) begin
            state_d = ACTIVE;
            last_d  = win_q;
            cnt_d   = '0;
          end
        end
        ACTIVE: begin
          if (spawn_done) begin
            state_d = COOLDOWN;
            cnt_d   = cool_load;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = COOLDOWN;
            cnt_d   = cool_load;
            tout_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        COOLDOWN: begin
          // A load of 0 or 1 both give a single cooldown cycle.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    spawn_valid = (state_q == OFFER);
    spawn_type  = ((state_q == OFFER) || (state_q == ACTIVE)) ? idx_to_type(win_q) : ENC_NONE;
    busy        = (state_q != IDLE);
    pending     = pending_q;
    drop_count  = drop_q;
    timeout_err = tout_q;
  end

  // State and bookkeeping registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 3'b000;
      pending_q <= 3'b000;
      drop_q    <= '0;
      tout_q    <= 1'b0;
      last_q    <= 2'd2;
      win_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= enc_req;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      tout_q    <= tout_d;
      last_q    <= last_d;
      win_q     <= win_d;
    end
  end

endmodule

// File: tb/tb_enc_spawn_scheduler.sv
// Directed self-checking bench for enc_spawn_scheduler (COOLDOWN_BASE=8, TIMEOUT=20).
module tb_enc_spawn_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       game_active;
  logic [2:0] enc_req;
  logic [1:0] difficulty;
  logic       spawn_ready;
  logic       spawn_done;
  logic       spawn_valid;
  logic [1:0] spawn_type;
  logic       busy;
  logic [2:0] pending;
  logic [7:0] drop_count;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  enc_spawn_scheduler #(
    .COOLDOWN_BASE (8),
    .TIMEOUT       (20),
    .CNT_W         (31),
    .DROP_W        (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .game_active (game_active),
    .enc_req     (enc_req),
    .difficulty  (difficulty),
    .spawn_ready (spawn_ready),
    .spawn_done  (spawn_done),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .busy        (busy),
    .pending     (pending),
    .drop_count  (drop_count),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    game_active = 1'b0;
    enc_req     = 3'b000;
    difficulty  = 2'd0;
    spawn_ready = 1'b0;
    spawn_done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for an offer, check its type, accept it and finish it at once.
  task automatic serve(input string tag, input logic [1:0] exp_type);
    int n = 0;
    while (!spawn_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(spawn_valid), 32'd1);
    chk({tag, "_type"}, 32'(spawn_type), 32'(exp_type));
    tick();
    chk({tag, "_act_v"}, 32'(spawn_valid), 32'd0);
    chk({tag, "_act_type"}, 32'(spawn_type), 32'(exp_type));
    spawn_done = 1'b1;
    tick();
    spawn_done = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    game_active = 1'b0;
    enc_req     = 3'b000;
    difficulty  = 2'd0;
    spawn_ready = 1'b0;
    spawn_done  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(spawn_valid), 32'd0);
    chk("rst_type", 32'(spawn_type), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_tout", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // 1: single request, done after 3 ACTIVE cycles, 8-cycle cooldown
    game_active = 1'b1;
    spawn_ready = 1'b1;
    enc_req     = 3'b010;
    tick();
    chk("t1_pend", 32'(pending), 32'd2);
    chk("t1_nv", 32'(spawn_valid), 32'd0);
    enc_req = 3'b000;
    tick();
    chk("t1_valid", 32'(spawn_valid), 32'd1);
    chk("t1_type", 32'(spawn_type), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_act_v", 32'(spawn_valid), 32'd0);
    chk("t1_act_type", 32'(spawn_type), 32'd2);
    chk("t1_act_pend", 32'(pending), 32'd0);
    tick();
    tick();
    spawn_done = 1'b1;
    tick();
    spawn_done = 1'b0;
    chk("t1_cd_type", 32'(spawn_type), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_cd_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_type", 32'(spawn_type), 32'd0);

    // 2: round-robin over a simultaneous batch, twice
    do_reset();
    game_active = 1'b1;
    spawn_ready = 1'b1;
    difficulty  = 2'd3;
    enc_req     = 3'b111;
    tick();
    chk("t2_pend", 32'(pending), 32'd7);
    enc_req = 3'b000;
    serve("t2_a1", 2'd1);
    serve("t2_a2", 2'd2);
    serve("t2_a3", 2'd3);
    enc_req = 3'b111;
    tick();
    enc_req = 3'b000;
    serve("t2_b1", 2'd1);
    serve("t2_b2", 2'd2);
    serve("t2_b3", 2'd3);

    // 3: drops, grant-clear coincident rise, saturation
    do_reset();
    game_active = 1'b1;
    spawn_ready = 1'b0;
    enc_req     = 3'b001;
    tick();
    chk("t3_pend", 32'(pending), 32'd1);
    enc_req = 3'b000;
    tick();
    chk("t3_offer", 32'(spawn_valid), 32'd1);
    enc_req = 3'b001;
    tick();
    chk("t3_drop1", 32'(drop_count), 32'd1);
    chk("t3_hold_v", 32'(spawn_valid), 32'd1);
    enc_req = 3'b000;
    tick();
    enc_req     = 3'b001;
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    chk("t3_clr_pend", 32'(pending), 32'd1);
    chk("t3_clr_drop", 32'(drop_count), 32'd1);
    chk("t3_clr_v", 32'(spawn_valid), 32'd0);
    for (int i = 0; i < 254; i++) begin
      enc_req = 3'b000;
      tick();
      enc_req = 3'b001;
      tick();
    end
    chk("t3_drop255", 32'(drop_count), 32'd255);
    enc_req = 3'b000;
    tick();
    enc_req = 3'b001;
    tick();
    chk("t3_sat", 32'(drop_count), 32'd255);

    // 4: difficulty scaling, difficulty change during cooldown ignored
    do_reset();
    game_active = 1'b1;
    spawn_ready = 1'b1;
    difficulty  = 2'd3;
    enc_req     = 3'b001;
    tick();
    enc_req = 3'b000;
    tick();
    tick();
    spawn_done = 1'b1;
    tick();
    spawn_done = 1'b0;
    chk("t4_d3_cd", 32'(busy), 32'd1);
    tick();
    chk("t4_d3_idle", 32'(busy), 32'd0);
    difficulty = 2'd2;
    enc_req    = 3'b001;
    tick();
    enc_req = 3'b000;
    tick();
    chk("t4_d2_offer", 32'(spawn_valid), 32'd1);
    tick();
    spawn_done = 1'b1;
    tick();
    spawn_done = 1'b0;
    chk("t4_d2_cd1", 32'(busy), 32'd1);
    difficulty = 2'd0;
    tick();
    chk("t4_d2_cd2", 32'(busy), 32'd1);
    tick();
    chk("t4_d2_idle", 32'(busy), 32'd0);

    // 5: timeout after 20 ACTIVE cycles, sticky flag
    do_reset();
    game_active = 1'b1;
    spawn_ready = 1'b1;
    difficulty  = 2'd3;
    enc_req     = 3'b001;
    tick();
    enc_req = 3'b000;
    tick();
    chk("t5_offer", 32'(spawn_valid), 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("t5_act_type", 32'(spawn_type), 32'd1);
      chk("t5_no_tout", 32'(timeout_err), 32'd0);
      tick();
    end
    chk("t5_tout", 32'(timeout_err), 32'd1);
    chk("t5_cd_busy", 32'(busy), 32'd1);
    chk("t5_cd_type", 32'(spawn_type), 32'd0);
    tick();
    chk("t5_idle", 32'(busy), 32'd0);
    spawn_done = 1'b1;
    tick();
    spawn_done = 1'b0;
    chk("t5_done_ign", 32'(busy), 32'd0);
    chk("t5_sticky", 32'(timeout_err), 32'd1);

    // 6: abort in OFFER, rises ignored while inactive, reset in ACTIVE
    spawn_ready = 1'b0;
    enc_req     = 3'b010;
    tick();
    enc_req = 3'b000;
    tick();
    chk("t6_offer", 32'(spawn_valid), 32'd1);
    game_active = 1'b0;
    tick();
    chk("t6_ab_v", 32'(spawn_valid), 32'd0);
    chk("t6_ab_pend", 32'(pending), 32'd0);
    chk("t6_ab_busy", 32'(busy), 32'd0);
    chk("t6_ab_type", 32'(spawn_type), 32'd0);
    chk("t6_ab_tout", 32'(timeout_err), 32'd1);
    enc_req = 3'b100;
    tick();
    chk("t6_low_pend", 32'(pending), 32'd0);
    game_active = 1'b1;
    tick();
    chk("t6_back_pend", 32'(pending), 32'd0);
    chk("t6_back_busy", 32'(busy), 32'd0);
    enc_req = 3'b001;
    tick();
    enc_req = 3'b000;
    tick();
    enc_req = 3'b001;
    tick();
    chk("t6_drop", 32'(drop_count), 32'd1);
    spawn_ready = 1'b1;
    tick();
    chk("t6_act_type", 32'(spawn_type), 32'd1);
    chk("t6_act_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_v", 32'(spawn_valid), 32'd0);
    chk("t6_rst_type", 32'(spawn_type), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'd0);
    chk("t6_rst_drop", 32'(drop_count), 32'd0);
    chk("t6_rst_tout", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
